mastermind_game_ctrl: RTL and testbench



---
 rtl/mastermind_pkg.sv | 32 +++
 rtl/mm_scorer.sv | 110 +++++++++++
 rtl/mastermind_game_ctrl.sv | 143 ++++++++++++++
 tb/tb_mastermind_game_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared types and constants for the Mastermind game sequencer.
//   NUM_DIGITS / DIG_W : code geometry (4 digits, 2 bits each)
//   digit_t, code_t    : one digit and one packed 4-digit code (dig0 = [1:0])
//   state_e            : game sequencer states
//   get_digit, min3    : small helpers used by the scorer
package mastermind_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 2;

  typedef logic [DIG_W-1:0]            digit_t;
  typedef logic [NUM_DIGITS*DIG_W-1:0] code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GUESS,
    ST_SCORE_EXACT,
    ST_SCORE_COLOR,
    ST_REPORT,
    ST_WIN,
    ST_LOSE
  } state_e;

  function automatic digit_t get_digit(input code_t code, input logic [1:0] idx);
    return code[idx*DIG_W +: DIG_W];
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mm_scorer.sv
// mm_scorer: multi-cycle Mastermind scoring datapath.
//   Exact pass (4 cycles): compares one digit position per cycle; mismatched
//   digits are counted into per-colour histograms for secret and guess.
//   Colour pass (4 cycles): sums min(hist_s[c], hist_g[c]) over colours c.
// Ports:
//   clk, srst      : clock, synchronous active-high reset
//   start_i        : 1-cycle pulse, clears accumulators and begins the exact pass
//   secret_i/guess_i : codes under comparison (held stable while busy)
//   exact_last_o   : high on the last exact-pass cycle
//   done_o         : high on the final colour cycle
//   exact_o        : exact-hit count (complete once the colour pass runs)
//   color_o        : colour-only count including the current colour term,
//                    so it is the final total while done_o is high
module mm_scorer
  import mastermind_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       start_i,
  input  code_t      secret_i,
  input  code_t      guess_i,
  output logic       exact_last_o,
  output logic       done_o,
  output logic [2:0] exact_o,
  output logic [2:0] color_o
);

  logic                         busy_q, busy_d;
  logic                         color_ph_q, color_ph_d;
  logic [1:0]                   idx_q, idx_d;
  logic [2:0]                   exact_acc_q, exact_acc_d;
  logic [2:0]                   color_acc_q, color_acc_d;
  logic [NUM_DIGITS-1:0][2:0]   hist_s_q, hist_s_d;
  logic [NUM_DIGITS-1:0][2:0]   hist_g_q, hist_g_d;

  digit_t     sec_dig, gue_dig;
  logic       hit, ex_act, col_act;
  logic [2:0] min_cur;

  assign sec_dig = get_digit(secret_i, idx_q);
  assign gue_dig = get_digit(guess_i, idx_q);
  assign hit     = (sec_dig == gue_dig);
  assign ex_act  = busy_q & ~color_ph_q;
  assign col_act = busy_q & color_ph_q;
  // In the colour pass idx_q doubles as the colour being summed.
  assign min_cur = min3(hist_s_q[idx_q], hist_g_q[idx_q]);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_hist
      logic inc_s, inc_g;
      assign inc_s = ex_act & ~hit & (sec_dig == digit_t'(gi));
      assign inc_g = ex_act & ~hit & (gue_dig == digit_t'(gi));
      assign hist_s_d[gi] = start_i ? 3'd0 : hist_s_q[gi] + 3'(inc_s);
      assign hist_g_d[gi] = start_i ? 3'd0 : hist_g_q[gi] + 3'(inc_g);
    end
  endgenerate

  always_comb begin
    busy_d      = busy_q;
    color_ph_d  = color_ph_q;
    idx_d       = idx_q;
    exact_acc_d = exact_acc_q;
    color_acc_d = color_acc_q;
    if (start_i) begin
      busy_d      = 1'b1;
      color_ph_d  = 1'b0;
      idx_d       = 2'd0;
      exact_acc_d = 3'd0;
      color_acc_d = 3'd0;
    end else if (ex_act) begin
      exact_acc_d = exact_acc_q + 3'(hit);
      idx_d       = idx_q + 2'd1;        // wraps to 0 for the colour pass
      if (idx_q == 2'd3) color_ph_d = 1'b1;
    end else if (col_act) begin
      color_acc_d = color_acc_q + min_cur;
      idx_d       = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        busy_d     = 1'b0;
        color_ph_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_q      <= 1'b0;
      color_ph_q  <= 1'b0;
      idx_q       <= 2'd0;
      exact_acc_q <= 3'd0;
      color_acc_q <= 3'd0;
      hist_s_q    <= '0;
      hist_g_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      color_ph_q  <= color_ph_d;
      idx_q       <= idx_d;
      exact_acc_q <= exact_acc_d;
      color_acc_q <= color_acc_d;
      hist_s_q    <= hist_s_d;
      hist_g_q    <= hist_g_d;
    end
  end

  assign exact_last_o = ex_act & (idx_q == 2'd3);
  assign done_o       = col_act & (idx_q == 2'd3);
  assign exact_o      = exact_acc_q;
  assign color_o      = color_acc_q + min_cur;

endmodule

// File: rtl/mastermind_game_ctrl.sv
// mastermind_game_ctrl: game sequencer for the 4-digit, 4-colour Mastermind.
// Captures the secret, accepts guesses over valid/ready, scores each guess
// with mm_scorer (4 exact cycles + 4 colour cycles), tracks attempts and
// declares win/loss.
// Optional build macro MM_SECRET_LFSR_EN: secret comes from a free-running
// 8-bit Fibonacci LFSR (taps 8,6,5,4) instead of secret_in.
// Ports:
//   CLOCK_50, reset : clock, synchronous active-high reset
//   start           : 1-cycle pulse, begins a new game
//   secret_in       : secret code (dig0 = [1:0])
//   guess_in/guess_valid/guess_ready : guess handshake (ready only in WAIT_GUESS)
//   score_valid     : 1-cycle pulse in REPORT
//   exact_cnt/color_cnt : last score
//   attempts        : guesses scored this game
//   game_won/game_lost  : terminal flags
//   secret_out      : secret while in WIN or LOSE, else 0
module mastermind_game_ctrl
  import mastermind_pkg::*;
#(
  parameter int         MAX_ATTEMPTS = 10,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] secret_in,
  input  logic [7:0] guess_in,
  input  logic       guess_valid,
  output logic       guess_ready,
  output logic       score_valid,
  output logic [2:0] exact_cnt,
  output logic [2:0] color_cnt,
  output logic [3:0] attempts,
  output logic       game_won,
  output logic       game_lost,
  output logic [7:0] secret_out
);

  state_e     state_q, state_d;
  code_t      secret_q, secret_d;
  code_t      guess_q, guess_d;
  logic [2:0] exact_q, exact_d;
  logic [2:0] color_q, color_d;
  logic [3:0] attempts_q, attempts_d;
  code_t      secret_src;
  logic       sc_start, sc_exact_last, sc_done;
  logic [2:0] sc_exact, sc_color;

`ifdef MM_SECRET_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  always_ff @(posedge CLOCK_50) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
  assign secret_src = lfsr_q;
`else
  assign secret_src = secret_in;
`endif

  mm_scorer u_scorer (
    .clk          (CLOCK_50),
    .srst         (reset),
    .start_i      (sc_start),
    .secret_i     (secret_q),
    .guess_i      (guess_q),
    .exact_last_o (sc_exact_last),
    .done_o       (sc_done),
    .exact_o      (sc_exact),
    .color_o      (sc_color)
  );

  always_comb begin
    state_d    = state_q;
    secret_d   = secret_q;
    guess_d    = guess_q;
    exact_d    = exact_q;
    color_d    = color_q;
    attempts_d = attempts_q;
    sc_start   = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT_GUESS, ST_WIN, ST_LOSE: begin
        // start beats a same-cycle guess_valid in WAIT_GUESS
        if (start) begin
          secret_d   = secret_src;
          attempts_d = 4'd0;
          exact_d    = 3'd0;
          color_d    = 3'd0;
          state_d    = ST_WAIT_GUESS;
        end else if (state_q == ST_WAIT_GUESS && guess_valid) begin
          guess_d  = guess_in;
          sc_start = 1'b1;
          state_d  = ST_SCORE_EXACT;
        end
      end
      ST_SCORE_EXACT: begin
        if (sc_exact_last) state_d = ST_SCORE_COLOR;
      end
      ST_SCORE_COLOR: begin
        if (sc_done) begin
          exact_d    = sc_exact;
          color_d    = sc_color;
          attempts_d = attempts_q + 4'd1;
          state_d    = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (exact_q == 3'd4)                         state_d = ST_WIN;
        else if (attempts_q == 4'(MAX_ATTEMPTS))     state_d = ST_LOSE;
        else                                         state_d = ST_WAIT_GUESS;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      secret_q   <= '0;
      guess_q    <= '0;
      exact_q    <= 3'd0;
      color_q    <= 3'd0;
      attempts_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      secret_q   <= secret_d;
      guess_q    <= guess_d;
      exact_q    <= exact_d;
      color_q    <= color_d;
      attempts_q <= attempts_d;
    end
  end

  assign guess_ready = (state_q == ST_WAIT_GUESS);
  assign score_valid = (state_q == ST_REPORT);
  assign game_won    = (state_q == ST_WIN);
  assign game_lost   = (state_q == ST_LOSE);
  assign secret_out  = (game_won || game_lost) ? secret_q : 8'h00;
  assign exact_cnt   = exact_q;
  assign color_cnt   = color_q;
  assign attempts    = attempts_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed testbench for mastermind_game_ctrl (built with MAX_ATTEMPTS = 3).
module tb_mastermind_game_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] secret_in = 8'h00;
  logic [7:0] guess_in = 8'h00;
  logic       guess_valid = 1'b0;
  logic       guess_ready, score_valid, game_won, game_lost;
  logic [2:0] exact_cnt, color_cnt;
  logic [3:0] attempts;
  logic [7:0] secret_out;

  int n_checks = 0;
  int n_fails  = 0;

  mastermind_game_ctrl #(.MAX_ATTEMPTS(3), .LFSR_SEED(8'hA5)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .secret_in   (secret_in),
    .guess_in    (guess_in),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .score_valid (score_valid),
    .exact_cnt   (exact_cnt),
    .color_cnt   (color_cnt),
    .attempts    (attempts),
    .game_won    (game_won),
    .game_lost   (game_lost),
    .secret_out  (secret_out)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_start(input logic [7:0] s);
    secret_in = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a guess for one accept edge; optionally leave guess_valid high.
  task automatic accept_guess(input logic [7:0] g, input bit hold);
    guess_in = g;
    guess_valid = 1'b1;
    tick();
    if (!hold) guess_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accept edge; returns the cycle in
  // which score_valid is seen (20 means it never came).
  task automatic wait_score(output int cyc);
    cyc = 1;
    while (!score_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    $display("score: guess=%h exact=%0d color=%0d attempts=%0d cycle=%0d",
             guess_in, exact_cnt, color_cnt, attempts, cyc);
  endtask

  // Counts score_valid pulses over n cycles.
  task automatic count_scores(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (score_valid) pulses++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; guess_valid = 1'b1;
    tick(); tick();
    n_checks++; if (guess_ready !== 1'b0) begin n_fails++; $display("FAIL reset_ready: got %b want 0", guess_ready); end
    n_checks++; if ({score_valid, game_won, game_lost} !== 3'b000) begin n_fails++; $display("FAIL reset_flags: got %b want 000", {score_valid, game_won, game_lost}); end
    n_checks++; if ({exact_cnt, color_cnt, attempts} !== 10'd0) begin n_fails++; $display("FAIL reset_counts: got %h want 0", {exact_cnt, color_cnt, attempts}); end
    n_checks++; if (secret_out !== 8'h00) begin n_fails++; $display("FAIL reset_secret: got %h want 00", secret_out); end
    reset = 1'b0; start = 1'b0; guess_valid = 1'b0;
    tick();
    n_checks++; if (guess_ready !== 1'b0) begin n_fails++; $display("FAIL idle_ready: got %b want 0", guess_ready); end
    $display("reset: done");
  endtask

`ifndef MM_SECRET_LFSR_EN
  task automatic test_win;
    int cyc;
    do_start(8'hE4);
    n_checks++; if (guess_ready !== 1'b1) begin n_fails++; $display("FAIL win_ready: got %b want 1", guess_ready); end
    accept_guess(8'hE4, 1'b0);
    wait_score(cyc);
    n_checks++; if (exact_cnt !== 3'd4) begin n_fails++; $display("FAIL win_exact: got %0d want 4", exact_cnt); end
    n_checks++; if (color_cnt !== 3'd0) begin n_fails++; $display("FAIL win_color: got %0d want 0", color_cnt); end
    n_checks++; if (attempts !== 4'd1) begin n_fails++; $display("FAIL win_attempts: got %0d want 1", attempts); end
    tick();
    n_checks++; if (game_won !== 1'b1) begin n_fails++; $display("FAIL win_flag: got %b want 1", game_won); end
    n_checks++; if (secret_out !== 8'hE4) begin n_fails++; $display("FAIL win_secret_out: got %h want e4", secret_out); end
    n_checks++; if (guess_ready !== 1'b0) begin n_fails++; $display("FAIL win_ready_low: got %b want 0", guess_ready); end
    tick(); tick(); tick();
    n_checks++; if ({game_won, attempts, exact_cnt} !== {1'b1, 4'd1, 3'd4}) begin n_fails++; $display("FAIL win_frozen: got %b/%0d/%0d want 1/1/4", game_won, attempts, exact_cnt); end
  endtask

  task automatic test_mixed;
    int cyc;
    do_start(8'hE4);
    accept_guess(8'h1B, 1'b0);          // guess 3,2,1,0
    wait_score(cyc);
    n_checks++; if (exact_cnt !== 3'd0) begin n_fails++; $display("FAIL mixed_exact: got %0d want 0", exact_cnt); end
    n_checks++; if (color_cnt !== 3'd4) begin n_fails++; $display("FAIL mixed_color: got %0d want 4", color_cnt); end
    tick();
    n_checks++; if (guess_ready !== 1'b1 || game_won !== 1'b0) begin n_fails++; $display("FAIL mixed_back_to_wait: got ready=%b won=%b want 1/0", guess_ready, game_won); end
  endtask

  task automatic test_latency;
    int cyc;
    do_start(8'h50);                    // secret 0,0,1,1
    accept_guess(8'h94, 1'b0);          // guess 0,1,1,2
    wait_score(cyc);
    // 4 exact cycles + 4 colour cycles, REPORT is the 9th cycle after accept
    n_checks++; if (cyc !== 9) begin n_fails++; $display("FAIL lat_cycle: got %0d want 9", cyc); end
    n_checks++; if (exact_cnt !== 3'd2) begin n_fails++; $display("FAIL lat_exact: got %0d want 2", exact_cnt); end
    n_checks++; if (color_cnt !== 3'd1) begin n_fails++; $display("FAIL lat_color: got %0d want 1", color_cnt); end
    tick();
    n_checks++; if (score_valid !== 1'b0) begin n_fails++; $display("FAIL lat_pulse_width: got %b want 0", score_valid); end
  endtask

  task automatic test_lose;
    int cyc, pulses;
    do_start(8'h24);                    // secret 0,1,2,0
    for (int i = 1; i <= 3; i++) begin
      accept_guess(8'hFF, 1'b0);
      wait_score(cyc);
      n_checks++; if ({exact_cnt, color_cnt} !== 6'd0) begin n_fails++; $display("FAIL lose_score%0d: got %0d/%0d want 0/0", i, exact_cnt, color_cnt); end
      n_checks++; if (attempts !== 4'(i)) begin n_fails++; $display("FAIL lose_attempts%0d: got %0d want %0d", i, attempts, i); end
      tick();
      if (i < 3) begin
        n_checks++; if (game_lost !== 1'b0 || guess_ready !== 1'b1) begin n_fails++; $display("FAIL lose_early%0d: got lost=%b ready=%b want 0/1", i, game_lost, guess_ready); end
      end
    end
    n_checks++; if (game_lost !== 1'b1) begin n_fails++; $display("FAIL lose_flag: got %b want 1", game_lost); end
    n_checks++; if (secret_out !== 8'h24) begin n_fails++; $display("FAIL lose_secret_out: got %h want 24", secret_out); end
    guess_in = 8'hFF; guess_valid = 1'b1;
    count_scores(12, pulses);
    guess_valid = 1'b0;
    n_checks++; if (pulses !== 0) begin n_fails++; $display("FAIL lose_extra_guess: got %0d pulses want 0", pulses); end
    n_checks++; if (attempts !== 4'd3 || game_lost !== 1'b1) begin n_fails++; $display("FAIL lose_hold: got %0d/%b want 3/1", attempts, game_lost); end
  endtask

  task automatic test_reset_mid_score;
    int pulses;
    do_start(8'hE4);
    accept_guess(8'hE4, 1'b1);
    for (int i = 0; i < 5; i++) tick();  // now in the colour pass
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({guess_ready, score_valid, game_won, game_lost} !== 4'b0000) begin n_fails++; $display("FAIL abort_flags: got %b want 0000", {guess_ready, score_valid, game_won, game_lost}); end
    n_checks++; if ({exact_cnt, color_cnt, attempts, secret_out} !== 18'd0) begin n_fails++; $display("FAIL abort_values: got %h want 0", {exact_cnt, color_cnt, attempts, secret_out}); end
    count_scores(12, pulses);
    guess_valid = 1'b0;
    n_checks++; if (pulses !== 0 || attempts !== 4'd0) begin n_fails++; $display("FAIL abort_no_score: got %0d pulses attempts %0d want 0/0", pulses, attempts); end
    $display("abort: reset during colour pass");
  endtask

  task automatic test_held_valid;
    int cyc, pulses;
    do_start(8'hE4);
    accept_guess(8'h1B, 1'b1);          // guess_valid stays high during scoring
    wait_score(cyc);
    guess_valid = 1'b0;
    n_checks++; if (cyc !== 9) begin n_fails++; $display("FAIL held_cycle: got %0d want 9", cyc); end
    count_scores(12, pulses);
    n_checks++; if (pulses !== 0) begin n_fails++; $display("FAIL held_second_score: got %0d pulses want 0", pulses); end
    n_checks++; if (attempts !== 4'd1 || guess_ready !== 1'b1) begin n_fails++; $display("FAIL held_state: got %0d/%b want 1/1", attempts, guess_ready); end
  endtask

  task automatic test_start_vs_guess;
    int cyc, pulses;
    do_start(8'hE4);
    accept_guess(8'h1B, 1'b0);
    wait_score(cyc);
    tick();
    secret_in = 8'h50; guess_in = 8'h50;
    start = 1'b1; guess_valid = 1'b1;
    tick();
    start = 1'b0; guess_valid = 1'b0;
    n_checks++; if ({exact_cnt, color_cnt, attempts} !== 10'd0) begin n_fails++; $display("FAIL restart_counts: got %h want 0", {exact_cnt, color_cnt, attempts}); end
    n_checks++; if (guess_ready !== 1'b1) begin n_fails++; $display("FAIL restart_ready: got %b want 1", guess_ready); end
    count_scores(12, pulses);
    n_checks++; if (pulses !== 0) begin n_fails++; $display("FAIL restart_scored: got %0d pulses want 0", pulses); end
    accept_guess(8'h50, 1'b0);
    wait_score(cyc);
    tick();
    n_checks++; if (game_won !== 1'b1 || secret_out !== 8'h50 || attempts !== 4'd1) begin n_fails++; $display("FAIL restart_new_secret: got won=%b secret=%h att=%0d want 1/50/1", game_won, secret_out, attempts); end
  endtask
`else
  logic [7:0] lfsr_m;
  always @(posedge CLOCK_50) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic test_lfsr;
    int cyc;
    logic [7:0] exp_a, exp_b;
    exp_a = lfsr_m;
    do_start(8'h00);
    accept_guess(exp_a, 1'b0);
    wait_score(cyc);
    tick();
    n_checks++; if (game_won !== 1'b1 || secret_out !== exp_a) begin n_fails++; $display("FAIL lfsr_first: got won=%b secret=%h want 1/%h", game_won, secret_out, exp_a); end
    do_start(8'h00);
    for (int i = 0; i < 4; i++) tick();
    exp_b = lfsr_m;                     // second start 5 cycles after the first
    do_start(8'h00);
    accept_guess(exp_b, 1'b0);
    wait_score(cyc);
    n_checks++; if (exact_cnt !== 3'd4) begin n_fails++; $display("FAIL lfsr_second_exact: got %0d want 4", exact_cnt); end
    tick();
    n_checks++; if (secret_out !== exp_b) begin n_fails++; $display("FAIL lfsr_second: got %h want %h", secret_out, exp_b); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef MM_SECRET_LFSR_EN
    test_win();
    test_mixed();
    test_latency();
    test_lose();
    test_reset_mid_score();
    test_held_valid();
    test_start_vs_guess();
`else
    test_lfsr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
